instr_mem_sync: RTL

Parametrised, clocked instruction memory for the single-cycle/multi-cycle processor datapath. It replaces the fixed 32x32 combinational ROM with the following:
- a registered fetch port with a request/valid handshake and stall;
- a program-load write port for filling memory at run time;
- a hardware clear sequence after reset.

It sits between the PC register and the instruction register/decoder, and the testbench or boot loader drives its load port.

---
 rtl/instr_mem_sync_pkg.sv | 22 ++
 rtl/instr_mem_sync_ram.sv | 38 +++
 rtl/instr_mem_sync.sv | 111 +++++++++++
 3 files changed

// File: rtl/instr_mem_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_sync_pkg
// Description : Shared constants for the clocked instruction memory and the
//               MIPS opcode fields used to assemble test programs.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_mem_sync_pkg;

    localparam logic [0:0]  c_ST_CLEAR    = 1'b0;
    localparam logic [0:0]  c_ST_RUN      = 1'b1;

    localparam logic [31:0] c_NOP_DEFAULT = 32'h0000_0000;

    localparam logic [5:0]  c_OP_RTYPE    = 6'h00;
    localparam logic [5:0]  c_OP_ORI      = 6'h0D;
    localparam logic [5:0]  c_OP_ADDI     = 6'h08;
    localparam logic [5:0]  c_OP_BGTZ     = 6'h07;
    localparam logic [5:0]  c_FN_ADD      = 6'h20;

endpackage
`default_nettype wire

// File: rtl/instr_mem_sync_ram.sv
`default_nettype none
// ============================================================================
// Module      : imem_ram
// Description : DEPTH x DATA_W synchronous RAM, one write and one read port,
//               read-first on a same-address collision.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rdata;

    // Both accesses sit in one block so the read samples the pre-write word.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/instr_mem_sync.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_sync
// Description : Clocked instruction memory with fetch handshake/stall, a
//               program-load port and a post-reset clear sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_sync
    import instr_mem_sync_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 5,
    parameter int          DEPTH    = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(c_NOP_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic              fetch_fault,
    output logic              load_err,
    output logic              busy
);

    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_LAST  = (ADDR_W+1)'(DEPTH - 1);

    logic [0:0]        r_state;
    logic [ADDR_W:0]   r_cnt;
    logic              r_ir_nop;
    logic              r_ir_valid;
    logic              r_fault;
    logic              r_load_err;

    logic              w_clear;
    logic              w_run;
    logic              w_pc_ok;
    logic              w_ld_ok;
    logic              w_accept;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;

    assign w_clear  = (r_state == c_ST_CLEAR);
    assign w_run    = (r_state == c_ST_RUN);
    assign w_pc_ok  = ({1'b0, pc} < c_DEPTH);
    assign w_ld_ok  = ({1'b0, load_addr} < c_DEPTH);
    assign w_accept = w_run & fetch_req & ~stall;

    // The clear sequence owns the write port; loads are only honoured in RUN.
    assign w_we    = ~rst & (w_clear | (w_run & load_we & w_ld_ok));
    assign w_waddr = w_clear ? r_cnt[ADDR_W-1:0] : load_addr;
    assign w_wdata = w_clear ? NOP_WORD : load_data;

    imem_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_accept & w_pc_ok),
        .i_raddr (pc),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_CLEAR;
            r_cnt      <= '0;
            r_ir_nop   <= 1'b1;
            r_ir_valid <= 1'b0;
            r_fault    <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= w_run & load_we & ~w_ld_ok;
            if (w_clear) begin
                r_cnt      <= r_cnt + 1'b1;
                r_ir_valid <= 1'b0;
                r_fault    <= 1'b0;
                if (r_cnt == c_LAST) begin
                    r_state <= c_ST_RUN;
                end
            end else if (!stall) begin
                r_ir_valid <= fetch_req;
                r_fault    <= fetch_req & ~w_pc_ok;
                // A faulted fetch presents NOP; an idle cycle keeps the last ir.
                if (fetch_req) begin
                    r_ir_nop <= ~w_pc_ok;
                end
            end
        end
    end

    assign ir          = r_ir_nop ? NOP_WORD : w_rdata;
    assign ir_valid    = r_ir_valid;
    assign fetch_fault = r_fault;
    assign load_err    = r_load_err;
    assign busy        = w_clear;

endmodule
`default_nettype wire
